// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback mux, 32x32 register file with write-through read ports, commit counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_reg_write,
  input  logic [1:0]        wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_alu_out,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_pc_plus4,
  input  logic [4:0]        wb_write_addr,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [31:0]       write_count
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [31:0]       write_count_q;
  logic [31:0]       write_count_d;

  // Writeback source select; the reserved encoding yields zero.
  always_comb begin
    wb_data = '0;
    unique case (wb_mem_to_reg)
      SEL_ALU:  wb_data = wb_alu_out;
      SEL_MEM:  wb_data = wb_read_data;
      SEL_LINK: wb_data = wb_pc_plus4;
      default:  wb_data = '0;
    endcase
  end

  // A write commits only for a real destination, a defined source, and outside reset.
  always_comb begin
    wb_commit = wb_reg_write & (wb_write_addr != 5'd0) & (wb_mem_to_reg != 2'd3) & ~reset;
  end

  // Register array update; r0 is cleared on reset and never written since commit excludes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_q[wb_write_addr] <= wb_data;
    end
  end

  // Next commit count; natural 32-bit wrap.
  always_comb begin
    write_count_d = write_count_q;
    if (wb_commit) begin
      write_count_d = write_count_q + 32'd1;
    end
  end

  // Commit counter state, updated on the same edge as the register write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  assign write_count = write_count_q;

  // Read port A: r0 is hardwired zero, an in-flight commit to the same register is forwarded.
  always_comb begin
    rs_data = '0;
    if (rs_addr == 5'd0) begin
      rs_data = '0;
    end else if (wb_commit && (rs_addr == wb_write_addr)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    rt_data = '0;
    if (rt_addr == 5'd0) begin
      rt_data = '0;
    end else if (wb_commit && (rt_addr == wb_write_addr)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        wb_reg_write;
  logic [1:0]  wb_mem_to_reg;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_read_data;
  logic [31:0] wb_pc_plus4;
  logic [4:0]  wb_write_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_commit;
  logic [31:0] write_count;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.DATA_W(32), .NREGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_out   (wb_alu_out),
    .wb_read_data (wb_read_data),
    .wb_pc_plus4  (wb_pc_plus4),
    .wb_write_addr(wb_write_addr),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_commit    (wb_commit),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [1:0] sel, input logic [4:0] addr,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
    wb_reg_write  = we;
    wb_mem_to_reg = sel;
    wb_write_addr = addr;
    wb_alu_out    = alu;
    wb_read_data  = mem;
    wb_pc_plus4   = pc4;
  endtask

  task automatic idle();
    set_wb(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    idle();

    // Reset state: commit blocked, reads zero, mux still live
    set_wb(1'b1, 2'd0, 5'd3, 32'h0000_0055, 32'h0, 32'h0);
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    tick();
    tick();
    chk("rst_count", write_count, 32'h0);
    chk("rst_commit", {31'h0, wb_commit}, 32'h0);
    chk("rst_rs", rs_data, 32'h0);
    chk("rst_rt", rt_data, 32'h0);
    chk("rst_wbdata", wb_data, 32'h0000_0055);

    idle();
    reset = 1'b0;
    tick();
    chk("post_rst_r3", rs_data, 32'h0);

    // Mux and commit for the three defined sources
    set_wb(1'b1, 2'd0, 5'd3, 32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222);
    #1;
    chk("sel0_wbdata", wb_data, 32'hA5A5_A5A5);
    chk("sel0_commit", {31'h0, wb_commit}, 32'h1);
    tick();
    set_wb(1'b1, 2'd1, 5'd4, 32'h3333_3333, 32'hDEAD_BEEF, 32'h4444_4444);
    #1;
    chk("sel1_wbdata", wb_data, 32'hDEAD_BEEF);
    tick();
    set_wb(1'b1, 2'd2, 5'd31, 32'h5555_5555, 32'h6666_6666, 32'h0040_0008);
    #1;
    chk("sel2_wbdata", wb_data, 32'h0040_0008);
    tick();
    idle();
    rs_addr = 5'd3;
    rt_addr = 5'd4;
    #1;
    chk("rd_r3", rs_data, 32'hA5A5_A5A5);
    chk("rd_r4", rt_data, 32'hDEAD_BEEF);
    rs_addr = 5'd31;
    #1;
    chk("rd_r31", rs_data, 32'h0040_0008);
    chk("count3", write_count, 32'd3);

    // Register zero is never written
    set_wb(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    rs_addr = 5'd0;
    #1;
    chk("r0_commit", {31'h0, wb_commit}, 32'h0);
    chk("r0_bypass", rs_data, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_read", rs_data, 32'h0);
    chk("r0_count", write_count, 32'd3);

    // Reserved select suppresses the write
    set_wb(1'b1, 2'd0, 5'd7, 32'h0000_0077, 32'h0, 32'h0);
    tick();
    set_wb(1'b1, 2'd3, 5'd7, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 32'hBAD2_BAD2);
    rs_addr = 5'd7;
    #1;
    chk("sel3_wbdata", wb_data, 32'h0);
    chk("sel3_commit", {31'h0, wb_commit}, 32'h0);
    chk("sel3_nobypass", rs_data, 32'h0000_0077);
    tick();
    idle();
    #1;
    chk("sel3_r7", rs_data, 32'h0000_0077);
    chk("sel3_count", write_count, 32'd4);

    // Write-through bypass on both ports to the same register
    set_wb(1'b1, 2'd0, 5'd9, 32'h0000_0011, 32'h0, 32'h0);
    tick();
    set_wb(1'b1, 2'd0, 5'd9, 32'h0000_0022, 32'h0, 32'h0);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
    chk("byp_rs", rs_data, 32'h0000_0022);
    chk("byp_rt", rt_data, 32'h0000_0022);
    tick();
    idle();
    #1;
    chk("byp_rs_next", rs_data, 32'h0000_0022);
    chk("byp_rt_next", rt_data, 32'h0000_0022);
    chk("byp_count", write_count, 32'd6);

    // Back-to-back writes to r10, last one wins
    rs_addr = 5'd10;
    rt_addr = 5'd10;
    set_wb(1'b1, 2'd0, 5'd10, 32'd1, 32'h0, 32'h0);
    tick();
    set_wb(1'b1, 2'd0, 5'd10, 32'd2, 32'h0, 32'h0);
    tick();
    set_wb(1'b1, 2'd0, 5'd10, 32'd3, 32'h0, 32'h0);
    tick();
    idle();
    #1;
    chk("b2b_r10", rs_data, 32'd3);
    chk("b2b_count", write_count, 32'd9);

    // Reset mid-cycle discards the pending write
    set_wb(1'b1, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    idle();
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    #1;
    chk("pre_rst_r5", rs_data, 32'h0000_1234);
    chk("pre_rst_count", write_count, 32'd10);
    set_wb(1'b1, 2'd0, 5'd6, 32'h0000_0066, 32'h0, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_r5", rs_data, 32'h0);
    chk("midrst_count", write_count, 32'h0);
    chk("midrst_commit", {31'h0, wb_commit}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("midrst_r6", rt_data, 32'h0);
    chk("midrst_count_after", write_count, 32'h0);

    // Counter wrap via backdoor preset
    dut.write_count_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preset", write_count, 32'hFFFF_FFFF);
    set_wb(1'b1, 2'd0, 5'd12, 32'h0000_0C0C, 32'h0, 32'h0);
    tick();
    idle();
    rs_addr = 5'd12;
    #1;
    chk("wrap_count", write_count, 32'h0);
    chk("wrap_r12", rs_data, 32'h0000_0C0C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
